// File: rtl/td4x_pkg.sv
// Shared types for the td4x core: opcodes, control state, ALU source select
// and the bit layout of the destination-load vector.
package td4x_pkg;

  typedef enum logic [3:0] {
    OP_ADD_A   = 4'b0000,
    OP_MOV_A_B = 4'b0001,
    OP_IN_A    = 4'b0010,
    OP_MOV_A   = 4'b0011,
    OP_MOV_B_A = 4'b0100,
    OP_ADD_B   = 4'b0101,
    OP_IN_B    = 4'b0110,
    OP_MOV_B   = 4'b0111,
    OP_HLT     = 4'b1000,
    OP_OUT_B   = 4'b1001,
    OP_OUT_IM  = 4'b1011,
    OP_JC      = 4'b1100,
    OP_JNC     = 4'b1110,
    OP_JMP     = 4'b1111
  } opcode_e;

  typedef enum logic {
    ST_HALT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SRC_A    = 2'd0,
    SRC_B    = 2'd1,
    SRC_IN   = 2'd2,
    SRC_ZERO = 2'd3
  } src_sel_e;

  // Positions inside the destination-load vector produced by the decoder.
  localparam int LD_A   = 0;
  localparam int LD_B   = 1;
  localparam int LD_OUT = 2;
  localparam int LD_PC  = 3;
  localparam int LD_W   = 4;

endpackage

// File: rtl/td4x_decoder.sv
// Combinational instruction decoder for td4x_core; width independent.
// Define TD4X_JC_EN to decode opcode 1100 as JC (jump if carry), otherwise it is a NOP.
module td4x_decoder
  import td4x_pkg::*;
(
  input  opcode_e           op_i,
  input  logic              carry_i,
  output src_sel_e          src_sel_o,
  output logic [LD_W-1:0]   load_o,
  output logic              carry_upd_o,
  output logic              is_halt_o
);

  // Unlisted opcodes fall through to the defaults: no load, carry cleared.
  always_comb begin
    src_sel_o   = SRC_ZERO;
    load_o      = '0;
    carry_upd_o = 1'b0;
    is_halt_o   = 1'b0;
    unique case (op_i)
      OP_ADD_A:   begin src_sel_o = SRC_A;    load_o[LD_A]   = 1'b1; carry_upd_o = 1'b1; end
      OP_ADD_B:   begin src_sel_o = SRC_B;    load_o[LD_B]   = 1'b1; carry_upd_o = 1'b1; end
      OP_MOV_A:   begin src_sel_o = SRC_ZERO; load_o[LD_A]   = 1'b1; carry_upd_o = 1'b1; end
      OP_MOV_B:   begin src_sel_o = SRC_ZERO; load_o[LD_B]   = 1'b1; carry_upd_o = 1'b1; end
      OP_MOV_A_B: begin src_sel_o = SRC_B;    load_o[LD_A]   = 1'b1; carry_upd_o = 1'b1; end
      OP_MOV_B_A: begin src_sel_o = SRC_A;    load_o[LD_B]   = 1'b1; carry_upd_o = 1'b1; end
      OP_IN_A:    begin src_sel_o = SRC_IN;   load_o[LD_A]   = 1'b1; carry_upd_o = 1'b1; end
      OP_IN_B:    begin src_sel_o = SRC_IN;   load_o[LD_B]   = 1'b1; carry_upd_o = 1'b1; end
      OP_OUT_B:   begin src_sel_o = SRC_B;    load_o[LD_OUT] = 1'b1; carry_upd_o = 1'b1; end
      OP_OUT_IM:  begin src_sel_o = SRC_ZERO; load_o[LD_OUT] = 1'b1; carry_upd_o = 1'b1; end
      OP_JMP:     begin src_sel_o = SRC_ZERO; load_o[LD_PC]  = 1'b1; carry_upd_o = 1'b1; end
      OP_JNC:     load_o[LD_PC] = ~carry_i;
`ifdef TD4X_JC_EN
      OP_JC:      load_o[LD_PC] = carry_i;
`endif
      OP_HLT:     is_halt_o = 1'b1;
      default:    ;
    endcase
  end

endmodule

// File: rtl/td4x_core.sv
// TD4-style A/B/OUT/PC register machine generalised to DATA_W bits, with a
// run/halt/single-step controller. Optional JC opcode via macro TD4X_JC_EN.
module td4x_core
  import td4x_pkg::*;
#(
  parameter int                DATA_W   = 4,
  parameter logic [DATA_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              tick,
  input  logic              run,
  input  logic              halt,
  input  logic              step,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] rom_addr,
  input  logic [DATA_W+3:0] rom_data,
  output logic [DATA_W-1:0] out_port,
  output logic [DATA_W-1:0] reg_a,
  output logic [DATA_W-1:0] reg_b,
  output logic [DATA_W-1:0] pc,
  output logic              carry,
  output logic              halted,
  output logic              retire
);

  localparam logic [DATA_W-1:0] PC_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic              pending_q, pending_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, out_q, out_d, pc_q, pc_d;
  logic              carry_q, carry_d;
  logic              retire_q, retire_d;

  opcode_e           op;
  logic [DATA_W-1:0] im;
  src_sel_e          src_sel;
  logic [LD_W-1:0]   load;
  logic              carry_upd;
  logic              is_halt;
  logic [DATA_W-1:0] src;
  logic [DATA_W:0]   sum;
  logic              exec;

  assign op = opcode_e'(rom_data[DATA_W+3:DATA_W]);
  assign im = rom_data[DATA_W-1:0];

  td4x_decoder u_dec (
    .op_i        (op),
    .carry_i     (carry_q),
    .src_sel_o   (src_sel),
    .load_o      (load),
    .carry_upd_o (carry_upd),
    .is_halt_o   (is_halt)
  );

  always_comb begin
    src = '0;
    unique case (src_sel)
      SRC_A:    src = a_q;
      SRC_B:    src = b_q;
      SRC_IN:   src = in_port;
      SRC_ZERO: src = '0;
      default:  src = '0;
    endcase
  end

  assign sum = {1'b0, src} + {1'b0, im};

  // A step arriving together with tick executes in that same cycle.
  assign exec = tick & ((state_q == ST_RUN) | pending_q | step);

  always_comb begin
    // NOTE: every _d starts from its _q so no branch can leave it unassigned and infer a latch.
    state_d   = state_q;
    pending_d = pending_q;
    a_d       = a_q;
    b_d       = b_q;
    out_d     = out_q;
    pc_d      = pc_q;
    carry_d   = carry_q;
    retire_d  = exec;

    if (exec) begin
      if (load[LD_A])   a_d   = sum[DATA_W-1:0];
      if (load[LD_B])   b_d   = sum[DATA_W-1:0];
      if (load[LD_OUT]) out_d = sum[DATA_W-1:0];
      pc_d    = load[LD_PC] ? sum[DATA_W-1:0] : pc_q + PC_ONE;
      carry_d = carry_upd & sum[DATA_W];
    end

    unique case (state_q)
      ST_HALT: begin
        pending_d = (pending_q | step) & ~exec;
        if (run && !halt) begin
          state_d   = ST_RUN;
          pending_d = 1'b0;
        end
      end
      ST_RUN: begin
        pending_d = 1'b0;
        if (halt || (exec && is_halt)) state_d = ST_HALT;
      end
      default: begin
        state_d   = ST_HALT;
        pending_d = 1'b0;
      end
    endcase
  end

  // NOTE: state uses non-blocking assignments; RST is synchronous so it sits inside the clocked branch.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_HALT;
      pending_q <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      out_q     <= '0;
      pc_q      <= RESET_PC;
      carry_q   <= 1'b0;
      retire_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      a_q       <= a_d;
      b_q       <= b_d;
      out_q     <= out_d;
      pc_q      <= pc_d;
      carry_q   <= carry_d;
      retire_q  <= retire_d;
    end
  end

  assign rom_addr = pc_q;
  assign pc       = pc_q;
  assign reg_a    = a_q;
  assign reg_b    = b_q;
  assign out_port = out_q;
  assign carry    = carry_q;
  assign halted   = (state_q == ST_HALT);
  assign retire   = retire_q;

endmodule

// File: tb/tb_td4x_core.sv
// Scoreboard bench for td4x_core: a 4-bit instance (RESET_PC=0) and an 8-bit
// instance (RESET_PC=0x0A); each retire pops an expected architectural state.
module tb_td4x_core;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] o;
    logic [7:0] p;
    logic       c;
    logic       h;
  } rec_t;

`ifdef TD4X_JC_EN
  localparam logic [7:0] JBASE = 8'h20;
`else
  localparam logic [7:0] JBASE = 8'h0D;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4, rst8, tick, run, halt, step;
  logic [7:0] in_port;

  logic [3:0] rom_addr4, out4, a4, b4, pc4;
  logic [7:0] rom_data4;
  logic       carry4, halted4, retire4;
  logic [7:0] rom_addr8, out8, a8, b8, pc8;
  logic [11:0] rom_data8;
  logic       carry8, halted8, retire8;

  logic [7:0]  rom4 [16];
  logic [11:0] rom8 [256];
  assign rom_data4 = rom4[rom_addr4];
  assign rom_data8 = rom8[rom_addr8];

  td4x_core #(.DATA_W(4), .RESET_PC(4'h0)) u_dut4 (
    .CLK(clk), .RST(rst4), .tick(tick), .run(run), .halt(halt), .step(step),
    .in_port(in_port[3:0]), .rom_addr(rom_addr4), .rom_data(rom_data4),
    .out_port(out4), .reg_a(a4), .reg_b(b4), .pc(pc4),
    .carry(carry4), .halted(halted4), .retire(retire4)
  );

  td4x_core #(.DATA_W(8), .RESET_PC(8'h0A)) u_dut8 (
    .CLK(clk), .RST(rst8), .tick(tick), .run(run), .halt(halt), .step(step),
    .in_port(in_port), .rom_addr(rom_addr8), .rom_data(rom_data8),
    .out_port(out8), .reg_a(a8), .reg_b(b8), .pc(pc8),
    .carry(carry8), .halted(halted8), .retire(retire8)
  );

  int   checks = 0;
  int   errors = 0;
  int   ret4_cnt = 0;
  int   ret8_cnt = 0;
  rec_t q4[$];
  rec_t q8[$];
  rec_t act4, act8, exp4, exp8;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic rec_t mk(input logic [7:0] a, b, o, p, input logic c, h);
    return {a, b, o, p, c, h};
  endfunction

  function automatic rec_t snap4();
    return {4'h0, a4, 4'h0, b4, 4'h0, out4, 4'h0, pc4, carry4, halted4};
  endfunction

  function automatic rec_t snap8();
    return {a8, b8, out8, pc8, carry8, halted8};
  endfunction

  // Monitors: every retire pulse is checked against the oldest expected state.
  always @(negedge clk) begin
    if (retire4 === 1'b1) begin
      ret4_cnt++;
      act4 = snap4();
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut4_retire: unexpected retire, state %0h", act4);
      end else begin
        exp4 = q4.pop_front();
        check("dut4_retire", 64'(act4), 64'(exp4));
      end
    end
  end

  always @(negedge clk) begin
    if (retire8 === 1'b1) begin
      ret8_cnt++;
      act8 = snap8();
      if (q8.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL dut8_retire: unexpected retire, state %0h", act8);
      end else begin
        exp8 = q8.pop_front();
        check("dut8_retire", 64'(act8), 64'(exp8));
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tick = 1'b0; run = 1'b0; halt = 1'b0; step = 1'b0;
  endtask

  task automatic reset4();
    rst4 = 1'b1;
    idle_inputs();
    cyc(); cyc();
    check("dut4_reset_state", 64'(snap4()), 64'(mk(8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b1)));
    check("dut4_reset_retire", 64'(retire4), 64'(1'b0));
    rst4 = 1'b0;
  endtask

  task automatic wait4(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (halted4 === 1'b1 && q4.size() == 0) break;
      cyc();
    end
    check(name, 64'(q4.size()), 64'(0));
  endtask

  int base;

  initial begin
    rst4 = 1'b1; rst8 = 1'b1;
    idle_inputs();
    in_port = 8'h06;
    for (int i = 0; i < 256; i++) rom8[i] = 12'h800;

    // Test 1: MOV A,3; ADD A,5; MOV B,A; OUT B; HLT
    for (int i = 0; i < 16; i++) rom4[i] = 8'h80;
    rom4[0] = 8'h33; rom4[1] = 8'h05; rom4[2] = 8'h40; rom4[3] = 8'h90; rom4[4] = 8'h80;
    reset4();
    base = ret4_cnt;
    q4.push_back(mk(8'h3, 8'h0, 8'h0, 8'h1, 1'b0, 1'b0));
    q4.push_back(mk(8'h8, 8'h0, 8'h0, 8'h2, 1'b0, 1'b0));
    q4.push_back(mk(8'h8, 8'h8, 8'h0, 8'h3, 1'b0, 1'b0));
    q4.push_back(mk(8'h8, 8'h8, 8'h8, 8'h4, 1'b0, 1'b0));
    q4.push_back(mk(8'h8, 8'h8, 8'h8, 8'h5, 1'b0, 1'b1));
    run = 1'b1; tick = 1'b1;
    cyc();
    run = 1'b0;
    wait4(40, "t1_drain");
    check("t1_retire_count", 64'(ret4_cnt - base), 64'(5));
    check("t1_out_port", 64'(out4), 64'(4'h8));
    check("t1_pc", 64'(pc4), 64'(4'h5));
    check("t1_halted", 64'(halted4), 64'(1'b1));
    tick = 1'b0;

    // Test 2/3: carry, JNC both ways, JMP, IN, ADD B overflow, MOV B,A, OUT B, HLT at 0xE
    for (int i = 0; i < 16; i++) rom4[i] = 8'h80;
    rom4[0]  = 8'h3F; rom4[1]  = 8'h01; rom4[2]  = 8'hE7; rom4[3]  = 8'h32;
    rom4[4]  = 8'h01; rom4[5]  = 8'hE7; rom4[7]  = 8'hFA; rom4[10] = 8'h63;
    rom4[11] = 8'h59; rom4[12] = 8'h44; rom4[13] = 8'h91; rom4[14] = 8'h80;
    rom4[15] = 8'h30;
    reset4();
    in_port = 8'h06;
    base = ret4_cnt;
    q4.push_back(mk(8'hF, 8'h0, 8'h0, 8'h1, 1'b0, 1'b0));
    q4.push_back(mk(8'h0, 8'h0, 8'h0, 8'h2, 1'b1, 1'b0));
    q4.push_back(mk(8'h0, 8'h0, 8'h0, 8'h3, 1'b0, 1'b0));
    q4.push_back(mk(8'h2, 8'h0, 8'h0, 8'h4, 1'b0, 1'b0));
    q4.push_back(mk(8'h3, 8'h0, 8'h0, 8'h5, 1'b0, 1'b0));
    q4.push_back(mk(8'h3, 8'h0, 8'h0, 8'h7, 1'b0, 1'b0));
    q4.push_back(mk(8'h3, 8'h0, 8'h0, 8'hA, 1'b0, 1'b0));
    q4.push_back(mk(8'h3, 8'h9, 8'h0, 8'hB, 1'b0, 1'b0));
    q4.push_back(mk(8'h3, 8'h2, 8'h0, 8'hC, 1'b1, 1'b0));
    q4.push_back(mk(8'h3, 8'h7, 8'h0, 8'hD, 1'b0, 1'b0));
    q4.push_back(mk(8'h3, 8'h7, 8'h8, 8'hE, 1'b0, 1'b0));
    q4.push_back(mk(8'h3, 8'h7, 8'h8, 8'hF, 1'b0, 1'b1));
    run = 1'b1; tick = 1'b1;
    cyc();
    run = 1'b0;
    wait4(60, "t2_drain");
    check("t2_retire_count", 64'(ret4_cnt - base), 64'(12));
    tick = 1'b0;

    // Test 4: step held 3 cycles with tick=0, then one tick executes MOV A,0 at 0xF (pc wraps)
    base = ret4_cnt;
    q4.push_back(mk(8'h0, 8'h7, 8'h8, 8'h0, 1'b0, 1'b1));
    step = 1'b1;
    cyc(); cyc(); cyc();
    step = 1'b0; tick = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    tick = 1'b0;
    check("t4_step_retires", 64'(ret4_cnt - base), 64'(1));
    check("t4_step_pc_wrap", 64'(pc4), 64'(4'h0));
    check("t4_step_halted", 64'(halted4), 64'(1'b1));

    // Step while in RUN must not leave a pending step behind
    base = ret4_cnt;
    run = 1'b1;
    cyc();
    run = 1'b0; step = 1'b1;
    cyc();
    step = 1'b0; halt = 1'b1;
    cyc();
    halt = 1'b0; tick = 1'b1;
    cyc(); cyc(); cyc();
    tick = 1'b0;
    check("t4_run_step_ignored", 64'(ret4_cnt - base), 64'(0));
    check("t4_run_step_pc", 64'(pc4), 64'(4'h0));

    // Test 5a: run and halt together keep the core halted
    run = 1'b1; halt = 1'b1; tick = 1'b1;
    cyc(); cyc(); cyc();
    check("t5_run_halt_halted", 64'(halted4), 64'(1'b1));
    check("t5_run_halt_no_exec", 64'(ret4_cnt - base), 64'(0));
    idle_inputs();

    // Test 5b: two instructions retire in RUN, then RST overrides run/step/tick
    q4.push_back(mk(8'hF, 8'h7, 8'h8, 8'h1, 1'b0, 1'b0));
    q4.push_back(mk(8'h0, 8'h7, 8'h8, 8'h2, 1'b1, 1'b0));
    run = 1'b1; tick = 1'b1;
    cyc();
    run = 1'b0;
    cyc(); cyc();
    rst4 = 1'b1; run = 1'b1; step = 1'b1;
    cyc();
    check("t5_rst_state", 64'(snap4()), 64'(mk(8'h0, 8'h0, 8'h0, 8'h0, 1'b0, 1'b1)));
    check("t5_rst_retire", 64'(retire4), 64'(1'b0));
    check("t5_rst_drain", 64'(q4.size()), 64'(0));
    idle_inputs();
    rst4 = 1'b1;

    // Test 6: 8-bit core, RESET_PC=0x0A, IN/ADD carry, JC or NOP, undefined op, MOV B, MOV A,B
    rom8[8'h0A] = 12'h200; rom8[8'h0B] = 12'h040; rom8[8'h0C] = 12'hC20;
    for (int k = 0; k < 2; k++) begin
      automatic logic [7:0] b = (k == 0) ? 8'h0D : 8'h20;
      rom8[b]        = 12'h0FF;
      rom8[b + 8'd1] = 12'hA33;
      rom8[b + 8'd2] = 12'hB55;
      rom8[b + 8'd3] = 12'h72E;
      rom8[b + 8'd4] = 12'h111;
      rom8[b + 8'd5] = 12'h800;
    end
    rst8 = 1'b1;
    cyc(); cyc();
    check("t6_reset_state", 64'(snap8()), 64'(mk(8'h0, 8'h0, 8'h0, 8'h0A, 1'b0, 1'b1)));
    rst8 = 1'b0;
    in_port = 8'hC8;
    base = ret8_cnt;
    q8.push_back(mk(8'hC8, 8'h00, 8'h00, 8'h0B, 1'b0, 1'b0));
    q8.push_back(mk(8'h08, 8'h00, 8'h00, 8'h0C, 1'b1, 1'b0));
    q8.push_back(mk(8'h08, 8'h00, 8'h00, JBASE, 1'b0, 1'b0));
    q8.push_back(mk(8'h07, 8'h00, 8'h00, JBASE + 8'd1, 1'b1, 1'b0));
    q8.push_back(mk(8'h07, 8'h00, 8'h00, JBASE + 8'd2, 1'b0, 1'b0));
    q8.push_back(mk(8'h07, 8'h00, 8'h55, JBASE + 8'd3, 1'b0, 1'b0));
    q8.push_back(mk(8'h07, 8'h2E, 8'h55, JBASE + 8'd4, 1'b0, 1'b0));
    q8.push_back(mk(8'h3F, 8'h2E, 8'h55, JBASE + 8'd5, 1'b0, 1'b0));
    q8.push_back(mk(8'h3F, 8'h2E, 8'h55, JBASE + 8'd6, 1'b0, 1'b1));
    run = 1'b1;
    cyc();
    run = 1'b0;
    for (int i = 0; i < 80; i++) begin
      if (halted8 === 1'b1 && q8.size() == 0) break;
      tick = ~tick;
      cyc();
    end
    check("t6_drain", 64'(q8.size()), 64'(0));
    check("t6_retire_count", 64'(ret8_cnt - base), 64'(9));
    check("t6_final_pc", 64'(pc8), 64'(JBASE + 8'd6));
    idle_inputs();
    rst8 = 1'b1;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
